tx_message_scheduler: RTL
=========================

# tx_message_scheduler

- Transmit-side counterpart of the acceptance filter: selects the next outgoing 128-bit CAN message and hands it to the CAN bit-level transmitter core.
- Sources, in priority order: the high-priority TX buffer (HPB), then the TX FIFO.
- Drives the request/acknowledge handshake to the core and tracks the result (success, arbitration lost, error).
- Applies retry and drop policy, and reports status to the register block.

## Interface
Parameters:
- MAX_RETRY, 8, errored attempts allowed before a message is dropped; 0 = unlimited (4-bit counter).
- RETRY_GAP, 3, idle cycles between a failed attempt and the next request (1..15).

Ports:
- i_sys_clk  in  1  system clock. Single clock domain; all inputs are synchronous to it.
- i_reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising i_sys_clk).
- i_tx_empty  in  1  TX FIFO empty.
- o_tx_r_en  out  1  TX FIFO read strobe, one-cycle pulse.
- i_tx_fifo_r_data  in  128  FIFO read data, valid the cycle after o_tx_r_en.
- i_hpb_valid  in  1  HPB holds a message.
- i_hpb_data  in  128  HPB message.
- o_hpb_clear  out  1  pulse: HPB message consumed.
- o_tx_message  out  128  message presented to the core. [127:96] is the ID word (same layout as the RX path).
- o_tx_request  out  1  transmit request to the core.
- i_tx_ack  in  1  core accepted the request (frame started).
- i_tx_done  in  1  pulse: frame sent successfully.
- i_tx_arb_lost  in  1  pulse: arbitration lost.
- i_tx_error  in  1  pulse: bit/ACK/form error.
- i_abort  in  1  software abort of the pending message.
- o_txok  out  1  pulse: message sent.
- o_tx_drop  out  1  pulse: message dropped (retry limit reached or abort).
- o_txbsy  out  1  scheduler holds a message.
- o_retry_cnt  out  4  error retries for the current message.

## Operation
All outputs are registered. Reset values: every output 0, o_tx_message = 0, retry counter = 0, state IDLE.

State machine: IDLE, FETCH, CAPTURE, REQUEST, WAIT_RESULT, RETRY_GAP.

- **IDLE**
  - If i_hpb_valid: latch i_hpb_data into o_tx_message, pulse o_hpb_clear, go to REQUEST.
  - Else if !i_tx_empty: pulse o_tx_r_en, go to FETCH.
  - HPB wins when both sources are ready. On entry to IDLE, the retry counter clears.
- **FETCH**: one wait cycle for FIFO read latency; go to CAPTURE.
- **CAPTURE**: latch i_tx_fifo_r_data into o_tx_message; go to REQUEST.
- **REQUEST**
  - o_tx_request = 1, held until i_tx_ack is sampled high, then go to WAIT_RESULT.
  - o_tx_request drops in the cycle after ack.
- **WAIT_RESULT**: o_tx_request = 0. When several result pulses arrive in the same cycle, priority is done > error > arb_lost.
  - i_tx_done: pulse o_txok, go to IDLE.
  - i_tx_error: increment the counter (saturating at 15).
    - If MAX_RETRY != 0 and the new count == MAX_RETRY: pulse o_tx_drop, go to IDLE.
    - Otherwise go to RETRY_GAP.
  - i_tx_arb_lost: go to RETRY_GAP; counter unchanged.
- **RETRY_GAP**: count RETRY_GAP cycles, then go to REQUEST with the same o_tx_message. No HPB preemption of a message already loaded.
- **i_abort**
  - In REQUEST before ack, or in RETRY_GAP: pulse o_tx_drop, go to IDLE, o_tx_request = 0 next cycle.
  - Ignored in IDLE, FETCH, CAPTURE and WAIT_RESULT (a frame on the bus cannot be cut).
- o_txbsy = (state != IDLE).
- o_tx_message holds its value after completion until the next load.
- Result pulses received outside WAIT_RESULT are ignored.

## Timing
- **HPB path**: i_hpb_valid high in IDLE at cycle N → o_hpb_clear = 1 and o_tx_request = 1 in cycle N+1.
- **FIFO path**: !i_tx_empty in IDLE at cycle N
  - o_tx_r_en = 1 in cycle N+1 (exactly one cycle);
  - data sampled at the end of cycle N+2;
  - o_tx_request = 1 in cycle N+3.
- **Ack**: i_tx_ack sampled at cycle M → o_tx_request = 0 in M+1.
- **Success**: i_tx_done at cycle K → o_txok = 1 in K+1, o_txbsy = 0 in K+1.
- **Retry**: result at cycle K → o_tx_request = 1 again in cycle K+1+RETRY_GAP.
- **Back-to-back**: a new selection can start in the first IDLE cycle after completion. At most one message is in flight.
- **Reset mid-operation**: i_reset low at cycle R → all outputs 0 in R+1; the message is abandoned with no o_tx_drop pulse.

## Test plan
1. **FIFO send**: i_tx_empty=0, FIFO data = 0xA5000000_…; ack 2 cycles after request, done 10 cycles later.
   - Expect o_tx_r_en single pulse; request 2 cycles after the r_en pulse; o_tx_message upper word = 0xA5000000.
   - Expect one o_txok pulse; o_txbsy low after it.
2. **Priority**: HPB valid and FIFO non-empty in the same cycle.
   - Expect the HPB message sent first, o_hpb_clear pulsed, no o_tx_r_en until the HPB message completes.
3. **Error retries**: MAX_RETRY=3; respond i_tx_error to every attempt.
   - Expect 3 requests, each spaced RETRY_GAP+1 cycles after its error, with o_retry_cnt 0→1→2.
   - After the 3rd error, expect an o_tx_drop pulse and no 4th request.
4. **Arbitration loss**: respond i_tx_arb_lost 5 times, then i_tx_done.
   - Expect o_retry_cnt to stay 0, 6 requests total, then o_txok.
5. **Abort**:
   - i_abort during RETRY_GAP: expect o_tx_drop and return to IDLE.
   - i_abort during WAIT_RESULT followed by i_tx_done: expect o_txok and no o_tx_drop.
6. **Reset**: assert i_reset=0 while o_tx_request=1.
   - Expect all outputs 0 next cycle; after release with FIFO non-empty, a fresh fetch starts.

Source files
------------

// File: rtl/tx_message_scheduler.sv
// Transmit message scheduler: picks the next CAN message (HPB before TX FIFO),
// runs the request/ack handshake with the bit-level core and applies retry/drop policy.
//
// state         | meaning
// S_IDLE        | no message held; select HPB or start a FIFO read
// S_FETCH       | FIFO read latency cycle
// S_CAPTURE     | latch FIFO read data
// S_REQUEST     | o_tx_request high until core acks
// S_WAIT_RESULT | frame on the bus; wait for done/error/arb_lost
// S_RETRY_GAP   | idle spacing before re-requesting the same message
module tx_message_scheduler #(
    parameter int MAX_RETRY = 8,
    parameter int RETRY_GAP = 3
) (
    input  logic         i_sys_clk,
    input  logic         i_reset,
    input  logic         i_tx_empty,
    output logic         o_tx_r_en,
    input  logic [127:0] i_tx_fifo_r_data,
    input  logic         i_hpb_valid,
    input  logic [127:0] i_hpb_data,
    output logic         o_hpb_clear,
    output logic [127:0] o_tx_message,
    output logic         o_tx_request,
    input  logic         i_tx_ack,
    input  logic         i_tx_done,
    input  logic         i_tx_arb_lost,
    input  logic         i_tx_error,
    input  logic         i_abort,
    output logic         o_txok,
    output logic         o_tx_drop,
    output logic         o_txbsy,
    output logic [3:0]   o_retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_REQUEST,
        S_WAIT_RESULT,
        S_RETRY_GAP
    } state_t;

    localparam logic [3:0] GAP_LOAD      = 4'(RETRY_GAP - 1);
    localparam logic [3:0] RETRY_LIMIT   = 4'(MAX_RETRY);
    localparam logic       RETRY_LIMITED = (MAX_RETRY != 0);

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_gap_cnt;
    logic [3:0]   w_gap_cnt_next;
    logic [3:0]   r_retry_cnt;
    logic [3:0]   w_retry_cnt_next;
    logic [3:0]   w_err_cnt;
    logic [127:0] r_tx_message;
    logic [127:0] w_tx_message_next;
    logic         r_tx_r_en;
    logic         w_tx_r_en_next;
    logic         r_hpb_clear;
    logic         w_hpb_clear_next;
    logic         r_txok;
    logic         w_txok_next;
    logic         r_tx_drop;
    logic         w_tx_drop_next;
    logic         r_tx_request;
    logic         r_txbsy;

    always_comb begin
        w_state_next      = r_state;
        w_gap_cnt_next    = r_gap_cnt;
        w_retry_cnt_next  = r_retry_cnt;
        w_tx_message_next = r_tx_message;
        w_tx_r_en_next    = 1'b0;
        w_hpb_clear_next  = 1'b0;
        w_txok_next       = 1'b0;
        w_tx_drop_next    = 1'b0;
        w_err_cnt         = (r_retry_cnt == 4'hF) ? 4'hF : r_retry_cnt + 4'd1;

        case (r_state)
            S_IDLE: begin
                if (i_hpb_valid) begin
                    w_tx_message_next = i_hpb_data;
                    w_hpb_clear_next  = 1'b1;
                    w_state_next      = S_REQUEST;
                end else if (!i_tx_empty) begin
                    w_tx_r_en_next = 1'b1;
                    w_state_next   = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_tx_message_next = i_tx_fifo_r_data;
                w_state_next      = S_REQUEST;
            end
            S_REQUEST: begin
                // Once the core has acked, the frame is on the bus and abort no longer applies.
                if (i_tx_ack) begin
                    w_state_next = S_WAIT_RESULT;
                end else if (i_abort) begin
                    w_tx_drop_next = 1'b1;
                    w_state_next   = S_IDLE;
                end
            end
            S_WAIT_RESULT: begin
                if (i_tx_done) begin
                    w_txok_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else if (i_tx_error) begin
                    w_retry_cnt_next = w_err_cnt;
                    if (RETRY_LIMITED && (w_err_cnt == RETRY_LIMIT)) begin
                        w_tx_drop_next = 1'b1;
                        w_state_next   = S_IDLE;
                    end else begin
                        w_gap_cnt_next = GAP_LOAD;
                        w_state_next   = S_RETRY_GAP;
                    end
                end else if (i_tx_arb_lost) begin
                    w_gap_cnt_next = GAP_LOAD;
                    w_state_next   = S_RETRY_GAP;
                end
            end
            S_RETRY_GAP: begin
                if (i_abort) begin
                    w_tx_drop_next = 1'b1;
                    w_state_next   = S_IDLE;
                end else if (r_gap_cnt == 4'd0) begin
                    w_state_next = S_REQUEST;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_state_next == S_IDLE) begin
            w_retry_cnt_next = 4'd0;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_gap_cnt    <= 4'd0;
            r_retry_cnt  <= 4'd0;
            r_tx_message <= 128'd0;
            r_tx_r_en    <= 1'b0;
            r_hpb_clear  <= 1'b0;
            r_txok       <= 1'b0;
            r_tx_drop    <= 1'b0;
            r_tx_request <= 1'b0;
            r_txbsy      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_gap_cnt    <= w_gap_cnt_next;
            r_retry_cnt  <= w_retry_cnt_next;
            r_tx_message <= w_tx_message_next;
            r_tx_r_en    <= w_tx_r_en_next;
            r_hpb_clear  <= w_hpb_clear_next;
            r_txok       <= w_txok_next;
            r_tx_drop    <= w_tx_drop_next;
            r_tx_request <= (w_state_next == S_REQUEST);
            r_txbsy      <= (w_state_next != S_IDLE);
        end
    end

    assign o_tx_r_en    = r_tx_r_en;
    assign o_hpb_clear  = r_hpb_clear;
    assign o_tx_message = r_tx_message;
    assign o_tx_request = r_tx_request;
    assign o_txok       = r_txok;
    assign o_tx_drop    = r_tx_drop;
    assign o_txbsy      = r_txbsy;
    assign o_retry_cnt  = r_retry_cnt;

endmodule
